// File: rtl/quad_step_decoder.sv
// Quadrature front end: synchronises and debounces raw A/B inputs, then decodes
// Gray-code transitions into a one-cycle step pulse with a direction level.
// Illegal double-bit jumps raise a one-cycle error pulse instead of a step.
module quad_step_decoder #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned DEB_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       qa,
  input  logic       qb,
  input  logic       en,
  output logic       count,
  output logic       inc,
  output logic       err,
  output logic [1:0] ab_state
);

  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       cand_prev_q;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d, deb_next;
  logic [1:0]       ab_q, ab_d;
  logic [1:0]       ab_old_q, ab_old_d;
  logic             upd_q, upd_d;
  logic             count_q, count_d;
  logic             inc_q, inc_d;
  logic             err_q, err_d;

  logic [1:0] cand;
  logic       cand_changed;
  logic       accept;
  logic       step_fwd, step_rev, step_bad;

  assign cand         = sync2_q;
  assign cand_changed = (cand != cand_prev_q);

  // Two-flop synchroniser per channel, plus a copy of the last candidate to detect changes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 2'b00;
      sync2_q     <= 2'b00;
      cand_prev_q <= 2'b00;
    end else begin
      sync1_q     <= {qa, qb};
      sync2_q     <= sync1_q;
      cand_prev_q <= sync2_q;
    end
  end

  // Debounce: count consecutive stable cycles of a candidate that differs from the accepted state.
  always_comb begin
    deb_next  = cand_changed ? DEB_W'(1) : deb_cnt_q + DEB_W'(1);
    deb_cnt_d = '0;
    accept    = 1'b0;
    ab_d      = ab_q;
    ab_old_d  = ab_old_q;
    upd_d     = 1'b0;
    if (cand != ab_q) begin
      if (deb_next == DEB_W'(DEB_CYCLES)) begin
        // Candidate has been stable long enough: adopt it and remember where we came from.
        accept   = 1'b1;
        ab_d     = cand;
        ab_old_d = ab_q;
        upd_d    = 1'b1;
      end else begin
        deb_cnt_d = deb_next;
      end
    end
  end

  // Classify the previous-to-current accepted state transition.
  always_comb begin
    step_fwd = 1'b0;
    step_rev = 1'b0;
    step_bad = 1'b0;
    unique case ({ab_old_q, ab_q})
      4'b0001, 4'b0111, 4'b1110, 4'b1000: step_fwd = 1'b1;
      4'b0010, 4'b1011, 4'b1101, 4'b0100: step_rev = 1'b1;
      4'b0011, 4'b1100, 4'b0110, 4'b1001: step_bad = 1'b1;
      default:                            ;
    endcase
  end

  // Output decode one edge after an accepted state change; en gates only the step.
  always_comb begin
    count_d = 1'b0;
    inc_d   = inc_q;
    err_d   = 1'b0;
    if (upd_q) begin
      if (step_bad) begin
        err_d = 1'b1;
      end else if (en && (step_fwd || step_rev)) begin
        count_d = 1'b1;
        inc_d   = step_fwd;
      end
    end
  end

  // Debounce state, accepted state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_cnt_q <= '0;
      ab_q      <= 2'b00;
      ab_old_q  <= 2'b00;
      upd_q     <= 1'b0;
      count_q   <= 1'b0;
      inc_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      ab_q      <= ab_d;
      ab_old_q  <= ab_old_d;
      upd_q     <= upd_d;
      count_q   <= count_d;
      inc_q     <= inc_d;
      err_q     <= err_d;
    end
  end

  assign count    = count_q;
  assign inc      = inc_q;
  assign err      = err_q;
  assign ab_state = ab_q;

  logic unused_accept;
  assign unused_accept = accept;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: directed quadrature sequences, a window-based reference
// model compared every cycle, and hand-computed pulse counts and latencies.
module tb_quad_step_decoder;

  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       qa = 1'b0, qb = 1'b0, en = 1'b1;
  logic       count, inc, err;
  logic [1:0] ab_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_count = 0, n_err = 0;
  int last_count_edge = -1;
  logic [2:0] ctr3 = 3'd0;

  quad_step_decoder #(.DEB_CYCLES(DEB), .DEB_W(4)) dut (
    .clk(clk), .reset(reset), .qa(qa), .qb(qb), .en(en),
    .count(count), .inc(inc), .err(err), .ab_state(ab_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Reference model: a raw value is accepted once the synchronised copy of it has been seen
  // on DEB consecutive edges while differing from the accepted state; outputs follow one edge on.
  logic [1:0] hist [0:DEB+1];
  logic [1:0] m_ab, m_old;
  bit         m_pend;
  logic       m_count, m_inc, m_err;

  function automatic int pos(input logic [1:0] s);
    case (s)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= DEB + 1; i++) hist[i] = 2'b00;
      m_ab = 2'b00; m_old = 2'b00; m_pend = 0;
      m_count = 0; m_inc = 0; m_err = 0;
    end else begin
      bit same;
      int d;
      m_count = 0;
      m_err   = 0;
      if (m_pend) begin
        d = (pos(m_ab) - pos(m_old) + 4) % 4;
        if (d == 2) m_err = 1;
        else if (en) begin
          m_count = 1;
          m_inc   = (d == 1);
        end
      end
      m_pend = 0;
      for (int i = DEB + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {qa, qb};
      same = 1;
      for (int i = 3; i <= DEB + 1; i++) if (hist[i] != hist[2]) same = 0;
      if (same && hist[2] != m_ab) begin
        m_old  = m_ab;
        m_ab   = hist[2];
        m_pend = 1;
      end
    end
  end

  // Per-cycle comparison against the model, plus pulse bookkeeping.
  always @(negedge clk) begin
    checks++;
    if ({count, inc, err, ab_state} !== {m_count, m_inc, m_err, m_ab}) begin
      failures++;
      $display("FAIL cycle_cmp edge=%0d got count=%b inc=%b err=%b ab=%b expected %b %b %b %b",
               cyc, count, inc, err, ab_state, m_count, m_inc, m_err, m_ab);
    end
    if (count === 1'b1) begin
      n_count++;
      last_count_edge = cyc;
      ctr3 = inc ? ctr3 + 3'd1 : ctr3 - 3'd1;
    end
    if (err === 1'b1) n_err++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Caller is at a negedge; drive a value, hold it for 'hold' edges, report count latency.
  task automatic step(input logic [1:0] v, input int hold, output int lat);
    int t0;
    {qa, qb} = v;
    t0 = cyc + 1;
    last_count_edge = -1;
    repeat (hold) @(negedge clk);
    lat = (last_count_edge < 0) ? -1 : last_count_edge - t0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  logic [1:0] fwd_seq [0:3];
  logic [1:0] rev_seq [0:3];
  int lat, base_c, base_e;

  initial begin
    fwd_seq[0] = 2'b01; fwd_seq[1] = 2'b11; fwd_seq[2] = 2'b10; fwd_seq[3] = 2'b00;
    rev_seq[0] = 2'b10; rev_seq[1] = 2'b11; rev_seq[2] = 2'b01; rev_seq[3] = 2'b00;

    repeat (3) @(negedge clk);
    chk("reset_ab", ab_state, 0);
    chk("reset_outs", {count, inc, err}, 0);
    reset = 1'b0;

    // 1: forward sequence
    base_c = n_count; base_e = n_err;
    for (int i = 0; i < 4; i++) begin
      step(fwd_seq[i], 10, lat);
      chk("fwd_latency", lat, 6);
      chk("fwd_inc", inc, 1);
    end
    chk("fwd_pulses", n_count - base_c, 4);
    chk("fwd_err", n_err - base_e, 0);
    chk("fwd_ab_end", ab_state, 0);

    // 2: reverse sequence, 3-bit counter from 0 wraps to 4
    base_c = n_count; ctr3 = 3'd0;
    for (int i = 0; i < 4; i++) begin
      step(rev_seq[i], 10, lat);
      chk("rev_latency", lat, 6);
      chk("rev_inc", inc, 0);
    end
    chk("rev_pulses", n_count - base_c, 4);
    chk("rev_ctr3", ctr3, 4);

    // 3: short glitches on qa
    base_c = n_count; base_e = n_err;
    for (int i = 0; i < 5; i++) begin
      step(2'b10, 2, lat);
      step(2'b00, 4, lat);
    end
    chk("glitch_pulses", n_count - base_c, 0);
    chk("glitch_err", n_err - base_e, 0);
    chk("glitch_ab", ab_state, 0);

    // 4: illegal jump 00 -> 11
    base_c = n_count; base_e = n_err;
    step(2'b11, 10, lat);
    chk("bad_err", n_err - base_e, 1);
    chk("bad_count", n_count - base_c, 0);
    chk("bad_ab", ab_state, 3);
    chk("bad_inc", inc, 0);

    {qa, qb} = 2'b00;
    do_reset();

    // 5: step with en low, then enabled
    en = 1'b0;
    base_c = n_count;
    step(2'b01, 10, lat);
    chk("en0_ab", ab_state, 1);
    chk("en0_count", n_count - base_c, 0);
    en = 1'b1;
    step(2'b11, 10, lat);
    chk("en1_count", n_count - base_c, 1);
    chk("en1_inc", inc, 1);
    chk("en1_latency", lat, 6);

    // 6: reset asserted mid-debounce clears outputs asynchronously
    step(2'b01, 3, lat);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_ab", ab_state, 0);
    chk("async_outs", {count, inc, err}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    base_c = n_count;
    step(2'b01, 10, lat);
    chk("post_rst_latency", lat, 6);
    chk("post_rst_pulses", n_count - base_c, 1);
    chk("post_rst_inc", inc, 1);
    chk("post_rst_ab", ab_state, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
